// File: rtl/uart_rx_frame_pkg.sv
// Shared UART framing constants and FSM state encodings, common to the receiver and transmitter.
package uart_rx_frame_pkg;
  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;
endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver link bundle: serial line in, byte valid/ready out, error pulses and busy status.
interface uart_rx_frame_if;
  import uart_rx_frame_pkg::*;

  logic                      rx_serial;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      parity_err;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;

  modport master (
    input  rx_serial, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output rx_serial, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line; 2-cycle latency, no backpressure.
// Resets to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: mid-bit sampling, start/parity/stop checks; byte out one cycle after the stop sample.
// 1-deep holding register: a good byte arriving while full and not accepted is dropped with an overrun pulse.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_frame_if.master link
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e               state_q, state_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_bad_q, par_bad_d;
  logic                      commit_good, commit_par, commit_frame;
  logic                      rx_s;

  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q, par_err_q, frame_err_q, overrun_q;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (link.rx_serial),
    .q   (rx_s)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    commit_good  = 1'b0;
    commit_par   = 1'b0;
    commit_frame = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (rx_s == UART_START_LVL) state_d = START;
      end
      START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (rx_s != UART_START_LVL) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = 3'd0;
            par_bad_d = 1'b0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          if (rx_s != UART_STOP_LVL) begin
            commit_frame = 1'b1;
            state_d      = BREAK;
          end else if (par_bad_q) begin
            commit_par = 1'b1;
            state_d    = IDLE;
          end else begin
            commit_good = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      BREAK: begin
        bit_cnt_d = '0;
        if (rx_s == UART_STOP_LVL) state_d = IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      par_err_q   <= commit_par;
      frame_err_q <= commit_frame;
      overrun_q   <= 1'b0;
      if (commit_good) begin
        if (!valid_q || link.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && link.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign link.rx_data    = data_q;
  assign link.rx_valid   = valid_q;
  assign link.parity_err = par_err_q;
  assign link.frame_err  = frame_err_q;
  assign link.overrun    = overrun_q;
  assign link.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: instance a has parity, instance b has none; CLKS_PER_BIT=16.
module tb_uart_rx_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  uart_rx_frame_if ia ();
  uart_rx_frame_if ib ();

  uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .link(ia.master)
  );
  uart_rx_frame #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .link(ib.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event counters sampled mid-cycle; tests work on deltas.
  int         valid_cyc = 0, acc_cnt = 0, par_cnt = 0, fr_cnt = 0, ovr_cnt = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_acc = 8'h00;
  int         b_acc = 0, b_err = 0;
  logic [7:0] b_last = 8'h00;

  always @(negedge clk) begin
    if (ia.rx_valid) valid_cyc++;
    if (ia.rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = ia.rx_valid;
    if (ia.rx_valid && ia.rx_ready) begin
      acc_cnt++;
      last_acc = ia.rx_data;
    end
    if (ia.parity_err) par_cnt++;
    if (ia.frame_err) fr_cnt++;
    if (ia.overrun) ovr_cnt++;
    if (ib.rx_valid && ib.rx_ready) begin
      b_acc++;
      b_last = ib.rx_data;
    end
    if (ib.parity_err || ib.frame_err || ib.overrun) b_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_b, input logic v);
    if (to_b) ib.rx_serial = v;
    else ia.rx_serial = v;
    tick(16);
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] d, input logic p,
                            input logic stop, input bit with_par);
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
    if (with_par) drive_bit(to_b, p);
    drive_bit(to_b, stop);
  endtask

  task automatic test_reset();
    ia.rx_serial = 1'b1; ib.rx_serial = 1'b1;
    ia.rx_ready = 1'b1;  ib.rx_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    checks++; if (ia.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", ia.rx_valid); end
    checks++; if (ia.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", ia.rx_data); end
    checks++; if ({ia.parity_err, ia.frame_err, ia.overrun} !== 3'b000) begin failures++; $display("FAIL reset_err: got %b want 000", {ia.parity_err, ia.frame_err, ia.overrun}); end
    checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
    checks++; if ({ib.rx_valid, ib.busy} !== 2'b00) begin failures++; $display("FAIL reset_b: got %b want 00", {ib.rx_valid, ib.busy}); end
    tick(1);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_good_byte();
    int v0, a0, e0, start_c, lat;
    v0 = valid_cyc; a0 = acc_cnt; e0 = par_cnt + fr_cnt + ovr_cnt;
    start_c = cyc;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    lat = rise_cyc - start_c;
    checks++; if (valid_cyc - v0 !== 1) begin failures++; $display("FAIL good_valid_cycles: got %0d want 1", valid_cyc - v0); end
    checks++; if (acc_cnt - a0 !== 1 || last_acc !== 8'hA5) begin failures++; $display("FAIL good_data: got %0d bytes last %h want 1 byte A5", acc_cnt - a0, last_acc); end
    checks++; if (par_cnt + fr_cnt + ovr_cnt - e0 !== 0) begin failures++; $display("FAIL good_no_err: got %0d pulses want 0", par_cnt + fr_cnt + ovr_cnt - e0); end
    // Mid-stop is 10.5 bits (168 clks) after the edge, plus synchronizer and output register.
    checks++; if (lat < 160 || lat > 180) begin failures++; $display("FAIL good_latency: got %0d want 160..180", lat); end
  endtask

  task automatic test_parity();
    int v0, a0, p0;
    v0 = valid_cyc; a0 = acc_cnt; p0 = par_cnt;
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    checks++; if (par_cnt - p0 !== 1) begin failures++; $display("FAIL parity_pulse: got %0d want 1", par_cnt - p0); end
    checks++; if (valid_cyc - v0 !== 0) begin failures++; $display("FAIL parity_no_valid: got %0d want 0", valid_cyc - v0); end
    tick(1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    checks++; if (acc_cnt - a0 !== 1 || last_acc !== 8'h3C) begin failures++; $display("FAIL parity_recover: got %0d bytes last %h want 1 byte 3C", acc_cnt - a0, last_acc); end
    checks++; if (par_cnt - p0 !== 1) begin failures++; $display("FAIL parity_recover_err: got %0d want 1", par_cnt - p0); end
    tick(1);
  endtask

  task automatic test_frame_err();
    int v0, f0, e0;
    v0 = valid_cyc; f0 = fr_cnt; e0 = par_cnt + ovr_cnt;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    tick(40);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %b want 1", ia.busy); end
    checks++; if (fr_cnt - f0 !== 1) begin failures++; $display("FAIL frame_pulse: got %0d want 1", fr_cnt - f0); end
    tick(1);
    ia.rx_serial = 1'b1;
    tick(6);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL break_release: got %b want 0", ia.busy); end
    tick(30);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b0 || fr_cnt - f0 !== 1 || valid_cyc - v0 !== 0 || par_cnt + ovr_cnt - e0 !== 0) begin
      failures++; $display("FAIL break_no_spurious: busy %b frame %0d valid %0d other %0d want 0 1 0 0",
                           ia.busy, fr_cnt - f0, valid_cyc - v0, par_cnt + ovr_cnt - e0);
    end
    tick(1);
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cyc; e0 = par_cnt + fr_cnt + ovr_cnt;
    ia.rx_serial = 1'b0;
    tick(4);
    ia.rx_serial = 1'b1;
    tick(1);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b1) begin failures++; $display("FAIL glitch_seen: got %b want 1", ia.busy); end
    tick(7);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: got %b want 0", ia.busy); end
    tick(40);
    @(negedge clk);
    checks++; if (valid_cyc - v0 !== 0 || par_cnt + fr_cnt + ovr_cnt - e0 !== 0) begin
      failures++; $display("FAIL glitch_nothing: valid %0d err %0d want 0 0", valid_cyc - v0, par_cnt + fr_cnt + ovr_cnt - e0);
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    int o0, a0;
    o0 = ovr_cnt; a0 = acc_cnt;
    ia.rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    checks++; if (ia.rx_valid !== 1'b1 || ia.rx_data !== 8'h11) begin failures++; $display("FAIL b2b_held: valid %b data %h want 1 11", ia.rx_valid, ia.rx_data); end
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL b2b_overrun: got %0d want 1", ovr_cnt - o0); end
    tick(1);
    ia.rx_ready = 1'b1;
    tick(1);
    ia.rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (ia.rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept: valid %b want 0", ia.rx_valid); end
    checks++; if (acc_cnt - a0 !== 1 || last_acc !== 8'h11) begin failures++; $display("FAIL b2b_accept_data: got %0d bytes last %h want 1 byte 11", acc_cnt - a0, last_acc); end
    tick(1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int a0;
    d = 8'h5A;
    ia.rx_ready = 1'b1;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
    ia.rx_serial = d[4];
    tick(8);
    @(negedge clk);
    checks++; if (ia.busy !== 1'b1 || ia.rx_data !== 8'h11) begin failures++; $display("FAIL pre_reset: busy %b data %h want 1 11", ia.busy, ia.rx_data); end
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({ia.rx_valid, ia.busy, ia.parity_err, ia.frame_err, ia.overrun} !== 5'b0 || ia.rx_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset_outputs: flags %b data %h want 00000 00",
                           {ia.rx_valid, ia.busy, ia.parity_err, ia.frame_err, ia.overrun}, ia.rx_data);
    end
    tick(1);
    ia.rx_serial = 1'b1;
    tick(24);
    a0 = acc_cnt;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    checks++; if (acc_cnt - a0 !== 1 || last_acc !== 8'h5A) begin failures++; $display("FAIL after_reset_rx: got %0d bytes last %h want 1 byte 5A", acc_cnt - a0, last_acc); end
    tick(1);
  endtask

  task automatic test_no_parity();
    int a0, e0;
    a0 = b_acc; e0 = b_err;
    send_frame(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    tick(4);
    @(negedge clk);
    checks++; if (b_acc - a0 !== 1 || b_last !== 8'h5A) begin failures++; $display("FAIL nopar_rx: got %0d bytes last %h want 1 byte 5A", b_acc - a0, b_last); end
    checks++; if (b_err - e0 !== 0 || ib.busy !== 1'b0) begin failures++; $display("FAIL nopar_clean: err %0d busy %b want 0 0", b_err - e0, ib.busy); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    test_no_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
